// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter sharing the data memory between load/store (M0) and fetch (M1).
// Grant registered on request, slave path combinational while granted; watchdog aborts unacked strobes.
module mem_bus_arbiter #(
   parameter int DWIDTH     = 32,
   parameter int SWIDTH     = DWIDTH / 8,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 15
) (
   input  logic                  ab_clk,
   input  logic                  ab_rst,
   input  logic                  ab_i_m0_cyc,
   input  logic                  ab_i_m0_stb,
   input  logic                  ab_i_m0_we,
   input  logic [ADDR_WIDTH-1:0] ab_i_m0_addr,
   input  logic [DWIDTH-1:0]     ab_i_m0_data,
   input  logic [SWIDTH-1:0]     ab_i_m0_sel,
   output logic                  ab_o_m0_ack,
   output logic                  ab_o_m0_err,
   output logic                  ab_o_m0_stall,
   output logic [DWIDTH-1:0]     ab_o_m0_data,
   input  logic                  ab_i_m1_cyc,
   input  logic                  ab_i_m1_stb,
   input  logic                  ab_i_m1_we,
   input  logic [ADDR_WIDTH-1:0] ab_i_m1_addr,
   input  logic [DWIDTH-1:0]     ab_i_m1_data,
   input  logic [SWIDTH-1:0]     ab_i_m1_sel,
   output logic                  ab_o_m1_ack,
   output logic                  ab_o_m1_err,
   output logic                  ab_o_m1_stall,
   output logic [DWIDTH-1:0]     ab_o_m1_data,
   output logic                  ab_o_cyc,
   output logic                  ab_o_stb,
   output logic                  ab_o_we,
   output logic [ADDR_WIDTH-1:0] ab_o_addr,
   output logic [DWIDTH-1:0]     ab_o_data,
   output logic [SWIDTH-1:0]     ab_o_sel,
   input  logic                  ab_i_ack,
   input  logic                  ab_i_stall,
   input  logic [DWIDTH-1:0]     ab_i_data
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;

   state_t          state, state_nxt;
   logic            owner, owner_nxt;
   logic            last, last_nxt;
   logic            err_q, err_nxt;
   logic            win;
   logic [TW-1:0]   tcnt, tcnt_nxt;

   logic                  own_cyc, own_stb, own_we, oth_cyc;
   logic [ADDR_WIDTH-1:0] own_addr;
   logic [DWIDTH-1:0]     own_data;
   logic [SWIDTH-1:0]     own_sel;

   assign own_cyc  = owner ? ab_i_m1_cyc  : ab_i_m0_cyc;
   assign own_stb  = owner ? ab_i_m1_stb  : ab_i_m0_stb;
   assign own_we   = owner ? ab_i_m1_we   : ab_i_m0_we;
   assign own_addr = owner ? ab_i_m1_addr : ab_i_m0_addr;
   assign own_data = owner ? ab_i_m1_data : ab_i_m0_data;
   assign own_sel  = owner ? ab_i_m1_sel  : ab_i_m0_sel;
   assign oth_cyc  = owner ? ab_i_m0_cyc  : ab_i_m1_cyc;

   always_ff @(posedge ab_clk) begin
      if (ab_rst) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         tcnt  <= tcnt_nxt;
         err_q <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      last_nxt      = last;
      tcnt_nxt      = tcnt;
      err_nxt       = 1'b0;
      win           = 1'b0;
      ab_o_cyc      = 1'b0;
      ab_o_stb      = 1'b0;
      ab_o_we       = 1'b0;
      ab_o_addr     = '0;
      ab_o_data     = '0;
      ab_o_sel      = '0;
      ab_o_m0_ack   = 1'b0;
      ab_o_m0_err   = 1'b0;
      ab_o_m0_stall = 1'b1;
      ab_o_m0_data  = '0;
      ab_o_m1_ack   = 1'b0;
      ab_o_m1_err   = 1'b0;
      ab_o_m1_stall = 1'b1;
      ab_o_m1_data  = '0;

      case (state)
         IDLE: begin
            if (ab_i_m0_cyc || ab_i_m1_cyc) begin
               // On a tie the master that was not granted last time wins
               win       = (ab_i_m0_cyc && ab_i_m1_cyc) ? ~last : ab_i_m1_cyc;
               state_nxt = win ? GNT1 : GNT0;
               owner_nxt = win;
               last_nxt  = win;
               tcnt_nxt  = '0;
            end
         end

         GNT0, GNT1: begin
            ab_o_cyc  = own_cyc;
            ab_o_stb  = own_cyc & own_stb;
            ab_o_we   = own_we;
            ab_o_addr = own_addr;
            ab_o_data = own_data;
            ab_o_sel  = own_sel;
            if (owner) begin
               ab_o_m1_ack   = ab_i_ack;
               ab_o_m1_stall = ab_i_stall;
               ab_o_m1_data  = ab_i_data;
            end else begin
               ab_o_m0_ack   = ab_i_ack;
               ab_o_m0_stall = ab_i_stall;
               ab_o_m0_data  = ab_i_data;
            end

            if (!own_cyc) begin
               tcnt_nxt = '0;
               if (oth_cyc) begin
                  win       = ~owner;
                  state_nxt = win ? GNT1 : GNT0;
                  owner_nxt = win;
                  last_nxt  = win;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (ab_i_ack) begin
               tcnt_nxt = '0;
            end else if (own_stb) begin
               // Ack in the final allowed cycle takes the branch above, so it beats the abort
               if (tcnt == TLAST) begin
                  state_nxt = ERR;
                  tcnt_nxt  = '0;
                  err_nxt   = 1'b1;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
         end

         ERR: begin
            if (owner) ab_o_m1_err = err_q;
            else       ab_o_m0_err = err_q;
            if (!own_cyc) begin
               if (oth_cyc) begin
                  win       = ~owner;
                  state_nxt = win ? GNT1 : GNT0;
                  owner_nxt = win;
                  last_nxt  = win;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter against a transaction-level grant/watchdog model.
module tb_mem_bus_arbiter;

   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]        cyc, stb, we;
   logic [1:0][31:0]  addr, wdat;
   logic [1:0][3:0]   sel;
   logic              i_ack, i_stall;
   logic [31:0]       i_data;
   logic              ack0, ack1, err0, err1, stall0, stall1;
   logic [31:0]       rdat0, rdat1;
   logic              o_cyc, o_stb, o_we;
   logic [31:0]       o_addr, o_data;
   logic [3:0]        o_sel;

   int errors = 0;
   int checks = 0;

   // Reference model: who holds the bus (-1 = nobody), whether that tenure was aborted,
   // how many strobe cycles have gone unacknowledged, and who won the last grant.
   int mw    = -1;
   bit mab   = 1'b0;
   bit mep   = 1'b0;
   int mwait = 0;
   int mlast = 1;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.DWIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
      .ab_clk(clk), .ab_rst(rst),
      .ab_i_m0_cyc(cyc[0]), .ab_i_m0_stb(stb[0]), .ab_i_m0_we(we[0]),
      .ab_i_m0_addr(addr[0]), .ab_i_m0_data(wdat[0]), .ab_i_m0_sel(sel[0]),
      .ab_o_m0_ack(ack0), .ab_o_m0_err(err0), .ab_o_m0_stall(stall0), .ab_o_m0_data(rdat0),
      .ab_i_m1_cyc(cyc[1]), .ab_i_m1_stb(stb[1]), .ab_i_m1_we(we[1]),
      .ab_i_m1_addr(addr[1]), .ab_i_m1_data(wdat[1]), .ab_i_m1_sel(sel[1]),
      .ab_o_m1_ack(ack1), .ab_o_m1_err(err1), .ab_o_m1_stall(stall1), .ab_o_m1_data(rdat1),
      .ab_o_cyc(o_cyc), .ab_o_stb(o_stb), .ab_o_we(o_we),
      .ab_o_addr(o_addr), .ab_o_data(o_data), .ab_o_sel(o_sel),
      .ab_i_ack(i_ack), .ab_i_stall(i_stall), .ab_i_data(i_data)
   );

   function automatic void model_step();
      int pick;
      pick = -1;
      mep  = 1'b0;
      if (rst) begin
         mw = -1; mab = 1'b0; mwait = 0; mlast = 1;
      end else if (mw < 0) begin
         if (cyc[0] && cyc[1]) pick = 1 - mlast;
         else if (cyc[0])      pick = 0;
         else if (cyc[1])      pick = 1;
         if (pick >= 0) begin
            mw = pick; mlast = pick; mwait = 0;
         end
      end else if (!cyc[mw]) begin
         if (cyc[1-mw]) begin
            mw = 1 - mw; mlast = mw;
         end else begin
            mw = -1;
         end
         mab = 1'b0; mwait = 0;
      end else if (!mab) begin
         if (i_ack) mwait = 0;
         else if (stb[mw]) begin
            mwait++;
            if (mwait == TIMEOUT) begin
               mab = 1'b1; mep = 1'b1; mwait = 0;
            end
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_inputs();
      cyc = '0; stb = '0; we = '0; addr = '0; wdat = '0; sel = '0;
      i_ack = 1'b0; i_stall = 1'b0; i_data = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1; cyc = 2'b11; stb = 2'b11; addr[0] = 32'hA0; addr[1] = 32'hB0;
      tick(); tick();
      i_ack = 1'b1; i_data = 32'hDEADBEEF; #1;
      checks++; if (o_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", o_cyc); end
      checks++; if ({stall0, stall1} !== 2'b11) begin errors++; $display("FAIL reset_stall: got %b want 11", {stall0, stall1}); end
      checks++; if ({ack0, ack1, err0, err1} !== 4'b0) begin errors++; $display("FAIL reset_ack_err: got %b want 0000", {ack0, ack1, err0, err1}); end
      checks++; if ({rdat0, rdat1} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {rdat0, rdat1}); end
      i_ack = 1'b0; rst = 1'b0;
      tick();
      checks++; if (o_cyc !== 1'b1 || o_addr !== 32'hA0 || stall1 !== 1'b1) begin
         errors++; $display("FAIL reset_first_tie: cyc=%b addr=%h stall1=%b want 1 a0 1", o_cyc, o_addr, stall1); end
      cyc = 2'b00;
      tick();
      checks++; if (o_cyc !== 1'b0) begin errors++; $display("FAIL reset_release: got %b want 0", o_cyc); end
   endtask

   task automatic test_m1_read();
      clear_inputs();
      cyc[1] = 1'b1; stb[1] = 1'b1; addr[1] = 32'h10; #1;
      checks++; if (o_cyc !== 1'b0) begin errors++; $display("FAIL read_pre_grant: got %b want 0", o_cyc); end
      tick();
      checks++; if (o_stb !== 1'b1 || o_addr !== 32'h10 || o_we !== 1'b0) begin
         errors++; $display("FAIL read_issue: stb=%b addr=%h we=%b want 1 10 0", o_stb, o_addr, o_we); end
      tick();
      i_ack = 1'b1; i_data = 32'hCAFEBABE; #1;
      checks++; if (ack1 !== 1'b1 || rdat1 !== 32'hCAFEBABE) begin
         errors++; $display("FAIL read_ack: ack=%b data=%h want 1 cafebabe", ack1, rdat1); end
      checks++; if (ack0 !== 1'b0 || rdat0 !== 32'h0 || stall0 !== 1'b1) begin
         errors++; $display("FAIL read_other: ack0=%b data0=%h stall0=%b want 0 0 1", ack0, rdat0, stall0); end
      tick();
      clear_inputs(); #1;
      checks++; if (o_cyc !== 1'b0 || o_stb !== 1'b0) begin errors++; $display("FAIL read_drop: cyc=%b stb=%b want 0 0", o_cyc, o_stb); end
      tick();
   endtask

   task automatic test_contention();
      clear_inputs();
      cyc = 2'b11; stb = 2'b11; addr[0] = 32'h100; addr[1] = 32'h200;
      tick();
      checks++; if (o_addr !== 32'h100 || stall1 !== 1'b1 || stall0 !== 1'b0) begin
         errors++; $display("FAIL cont_first: addr=%h stall1=%b stall0=%b want 100 1 0", o_addr, stall1, stall0); end
      i_ack = 1'b1; #1;
      checks++; if ({ack0, ack1} !== 2'b10) begin errors++; $display("FAIL cont_ack: got %b want 10", {ack0, ack1}); end
      tick();
      i_ack = 1'b0; cyc[0] = 1'b0; #1;
      checks++; if (o_cyc !== 1'b0 || stall1 !== 1'b1) begin errors++; $display("FAIL cont_drop: cyc=%b stall1=%b want 0 1", o_cyc, stall1); end
      tick();
      checks++; if (o_cyc !== 1'b1 || o_addr !== 32'h200 || stall0 !== 1'b1 || stall1 !== 1'b0) begin
         errors++; $display("FAIL cont_handoff: cyc=%b addr=%h stall0=%b stall1=%b want 1 200 1 0", o_cyc, o_addr, stall0, stall1); end
      cyc = 2'b00;
      tick();
      cyc = 2'b11;
      tick();
      checks++; if (o_addr !== 32'h100 || stall1 !== 1'b1) begin
         errors++; $display("FAIL cont_second_tie: addr=%h stall1=%b want 100 1", o_addr, stall1); end
      clear_inputs();
      tick();
   endtask

   task automatic test_byte_store();
      clear_inputs();
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1; sel[0] = 4'b0010; wdat[0] = 32'h00002200;
      tick();
      checks++; if ({o_we, o_sel, o_addr, o_data} !== {1'b1, 4'b0010, 32'h1, 32'h00002200}) begin
         errors++; $display("FAIL store_pass: we=%b sel=%b addr=%h data=%h want 1 0010 1 2200", o_we, o_sel, o_addr, o_data); end
      i_ack = 1'b1; #1;
      checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0 || stall1 !== 1'b1 || err1 !== 1'b0) begin
         errors++; $display("FAIL store_ack: ack0=%b ack1=%b stall1=%b err1=%b want 1 0 1 0", ack0, ack1, stall1, err1); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_timeout();
      int err_cnt, err_at;
      logic cyc_at14, cyc_at15;
      err_cnt = 0; err_at = -1; cyc_at14 = 1'bx; cyc_at15 = 1'bx;
      clear_inputs();
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 32'h40;
      tick();
      for (int i = 0; i < 20; i++) begin
         if (err0 === 1'b1) begin err_cnt++; err_at = i; end
         if (i == 14) cyc_at14 = o_cyc;
         if (i == 15) cyc_at15 = o_cyc;
         if (i == 10) cyc[1] = 1'b1;
         tick();
      end
      checks++; if (err_cnt != 1 || err_at != 15) begin
         errors++; $display("FAIL timeout_err_pulse: count=%0d at=%0d want 1 at 15", err_cnt, err_at); end
      checks++; if (cyc_at14 !== 1'b1 || cyc_at15 !== 1'b0) begin
         errors++; $display("FAIL timeout_abort: cyc14=%b cyc15=%b want 1 0", cyc_at14, cyc_at15); end
      i_ack = 1'b1; #1;
      checks++; if (o_cyc !== 1'b0 || stall0 !== 1'b1 || stall1 !== 1'b1 || ack0 !== 1'b0 || err0 !== 1'b0) begin
         errors++; $display("FAIL timeout_hold: cyc=%b st0=%b st1=%b ack0=%b err0=%b want 0 1 1 0 0", o_cyc, stall0, stall1, ack0, err0); end
      i_ack = 1'b0; cyc[0] = 1'b0;
      tick();
      checks++; if (o_cyc !== 1'b1 || stall1 !== 1'b0) begin
         errors++; $display("FAIL timeout_exit: cyc=%b stall1=%b want 1 0", o_cyc, stall1); end
      clear_inputs();
      tick();
   endtask

   task automatic test_ack_at_limit();
      clear_inputs();
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 32'h44;
      tick();
      repeat (14) tick();
      i_ack = 1'b1; #1;
      checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL limit_ack: got %b want 1", ack0); end
      tick();
      i_ack = 1'b0; #1;
      checks++; if (err0 !== 1'b0 || o_cyc !== 1'b1) begin errors++; $display("FAIL limit_no_err: err=%b cyc=%b want 0 1", err0, o_cyc); end
      repeat (14) tick();
      checks++; if (err0 !== 1'b0 || o_cyc !== 1'b1) begin errors++; $display("FAIL limit_restart: err=%b cyc=%b want 0 1", err0, o_cyc); end
      tick();
      checks++; if (err0 !== 1'b1 || o_cyc !== 1'b0) begin errors++; $display("FAIL limit_second_abort: err=%b cyc=%b want 1 0", err0, o_cyc); end
      cyc[0] = 1'b0;
      tick();
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      cyc[1] = 1'b1; stb[1] = 1'b1; addr[1] = 32'h80;
      tick(); tick();
      checks++; if (o_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", o_cyc); end
      rst = 1'b1;
      tick();
      i_ack = 1'b1; #1;
      checks++; if (o_cyc !== 1'b0 || ack1 !== 1'b0 || err1 !== 1'b0 || stall1 !== 1'b1 || stall0 !== 1'b1) begin
         errors++; $display("FAIL rstmid_post: cyc=%b ack1=%b err1=%b st1=%b st0=%b want 0 0 0 1 1", o_cyc, ack1, err1, stall1, stall0); end
      clear_inputs(); rst = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [70:0] exp_s, got_s;
      logic [69:0] exp_m, got_m;
      logic live, own0, own1;
      int ph;
      for (int i = 0; i < 3000; i++) begin
         ph = (i / 250) % 3;
         rst = ($urandom_range(299) == 0);
         for (int x = 0; x < 2; x++) begin
            if ($urandom_range(ph == 0 ? 31 : 7) == 0) cyc[x] = ~cyc[x];
            stb[x]  = ($urandom_range(3) != 0);
            we[x]   = 1'($urandom);
            addr[x] = $urandom;
            wdat[x] = $urandom;
            sel[x]  = 4'($urandom);
         end
         i_ack   = (ph == 0) ? 1'b0 : (ph == 1) ? ($urandom_range(15) == 0) : ($urandom_range(2) == 0);
         i_stall = ($urandom_range(3) == 0);
         i_data  = $urandom;
         #1;
         live = (mw >= 0) && !mab;
         own0 = live && (mw == 0);
         own1 = live && (mw == 1);
         if (live) exp_s = {cyc[mw], cyc[mw] & stb[mw], we[mw], addr[mw], wdat[mw], sel[mw]};
         else      exp_s = '0;
         exp_m = {own0 & i_ack, mab && (mw == 0) && mep, own0 ? i_stall : 1'b1, own0 ? i_data : 32'h0,
                  own1 & i_ack, mab && (mw == 1) && mep, own1 ? i_stall : 1'b1, own1 ? i_data : 32'h0};
         got_s = {o_cyc, o_stb, o_we, o_addr, o_data, o_sel};
         got_m = {ack0, err0, stall0, rdat0, ack1, err1, stall1, rdat1};
         checks++; if (got_s !== exp_s) begin
            errors++; $display("FAIL rand_slave cycle %0d: got %h want %h", i, got_s, exp_s); end
         checks++; if (got_m !== exp_m) begin
            errors++; $display("FAIL rand_master cycle %0d: got %h want %h", i, got_m, exp_m); end
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      #400000;
      $display("FAIL time_limit: bench did not reach its summary");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_m1_read();
      test_contention();
      test_byte_store();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave Wishbone-style bus arbiter that shares the single data memory between the memory stage (M0, load/store) and the fetch stage (M1, instruction reads). It sits between those pipeline stages and the memory model and grants the bus per bus cycle (`cyc`). Grants alternate round-robin on contention. A per-transfer watchdog aborts transfers the slave never acknowledges and reports a bus error to the owning master.

## Interface
Parameters:
- `DWIDTH`, 32, data width; `SWIDTH = DWIDTH/8` byte-select width
- `ADDR_WIDTH`, 32, byte address width
- `TIMEOUT`, 15, cycles without ack before abort (≥2)

Ports (x ∈ {0,1}):
- `ab_clk` in 1: clock, all state on rising edge
- `ab_rst` in 1: synchronous, active-high reset
- `ab_i_mx_cyc` in 1: master x owns/requests a bus cycle
- `ab_i_mx_stb` in 1: master x transfer strobe
- `ab_i_mx_we` in 1: 1 = write
- `ab_i_mx_addr` in ADDR_WIDTH: byte address
- `ab_i_mx_data` in DWIDTH: write data
- `ab_i_mx_sel` in SWIDTH: byte enables
- `ab_o_mx_ack` out 1: transfer done
- `ab_o_mx_err` out 1: one-cycle timeout error pulse
- `ab_o_mx_stall` out 1: master must hold request
- `ab_o_mx_data` out DWIDTH: read data
- `ab_o_cyc`, `ab_o_stb`, `ab_o_we` out 1: to slave
- `ab_o_addr` out ADDR_WIDTH, `ab_o_data` out DWIDTH, `ab_o_sel` out SWIDTH: to slave
- `ab_i_ack` in 1, `ab_i_stall` in 1, `ab_i_data` in DWIDTH: from slave

## Operation
- States: IDLE, GNT0, GNT1, ERR. Registers: `owner` (1b), `last` (1b, last granted master), `tcnt` (clog2(TIMEOUT+1) bits), `err_q`.
- IDLE: if only one `cyc` high → GNTx. If both → GNTx for x ≠ `last`. Set `owner`, `last` = x.
- GNTx: slave outputs are combinational copies of master x inputs; `ab_o_mx_ack` = `ab_i_ack`, `ab_o_mx_data` = `ab_i_data`, `ab_o_mx_stall` = `ab_i_stall`. Non-owner: stall = 1, ack = 0, err = 0, data = 0.
- Release: when owner `cyc` is sampled low in GNTx, go to GNTy if other master's `cyc` is high (no IDLE bubble); otherwise go to IDLE. `cyc` low forces `ab_o_cyc` and `ab_o_stb` low in that same cycle.
- Watchdog: in GNTx, `tcnt` increments each cycle with `ab_o_stb`=1 and `ab_i_ack`=0. It clears to 0 on ack or any state change. When `tcnt` = TIMEOUT−1 with no ack → ERR.
- ERR: slave `cyc`/`stb` = 0. `ab_o_m<owner>_err` = 1 for the first ERR cycle only (`err_q`). Owner stall = 1. Leave when owner `cyc` is low: go to GNTy if other is requesting, else IDLE.
- Slave ack outside GNTx is ignored, not forwarded.
- Owner `we`/`sel`/`addr`/`data` pass through unchanged; no width conversion.

## Timing
- Reset (sync, takes effect at the edge with `ab_rst`=1): state IDLE, `last`=1 (M0 wins first tie), `tcnt`=0, `err_q`=0.
- Outputs in reset/IDLE: all slave outputs 0; both stalls 1; acks 0; errs 0; master data 0.
- Grant latency: request sampled at edge N → GNT from N; slave sees `cyc`/`stb` in cycle N+1 (one cycle).
- Ack/data path master↔slave is combinational: zero added latency while granted.
- Back-to-back handoff: owner drops `cyc` in cycle K → other master granted from edge K+1.
- Ack and timeout in the same cycle: ack wins; no error.
- Reset mid-transfer: slave `cyc` is low in the cycle after the reset edge; no ack or err is emitted.

## Test plan
- Reset: hold `ab_rst`=1 for 2 cycles with both masters requesting → `ab_o_cyc`=0, both stalls=1, acks/errs=0. First grant after release goes to M0.
- M1 read of 0x10 alone: `cyc`/`stb` at N → `ab_o_addr`=0x10, `ab_o_stb`=1 at N+1. Slave acks with 0xCAFEBABE at N+2 → `ab_o_m1_ack`=1 and `ab_o_m1_data`=0xCAFEBABE in the same cycle.
- Contention: both request in IDLE → M0 granted, M1 stall=1 throughout. M0 drops `cyc` → M1 granted next edge with no IDLE cycle. Next tie → M0 wins.
- M0 byte store: addr 0x1, sel 0010, data 0x00002200, we=1 → slave sees identical we/sel/addr/data. Ack → `ab_o_m0_ack`=1 and M1 unaffected.
- Timeout (TIMEOUT=15): slave never acks → `ab_o_m0_err` is high for exactly 1 cycle, 15 cycles after the first stb cycle, and `ab_o_cyc` goes 0. The arbiter stays in ERR until M0 drops `cyc`.
- Ack on the 15th stalled cycle → ack, no err. Assert `ab_rst` mid-transfer → `ab_o_cyc`=0 the next cycle and state IDLE.
